weight_fetch: RTL and testbench
===============================

// Module: weight_fetch
// PURPOSE
//   Fetches one weight set (4 kernels x 9 taps) from the weight memory, one weight per read.
//   Packs each kernel into a 9*WEIGHT_WIDTH bus and pulses load_done.
//   Sits directly upstream of the weight latch controller:
//     - load_start comes from that controller.
//     - load_done and weight0..3_out go to that controller.
//   Steps through a layer's weight sets in order and wraps at the end of the layer.
// PARAMETERS
//   WEIGHT_WIDTH  8   bits per weight
//   ADDR_WIDTH    12  weight memory address width
//   RD_LAT        1   memory read latency in cycles, 1..3
// PORTS
//   clk         in   1               clock; all logic on posedge
//   rst         in   1               asynchronous, active-high reset
//   cfg_load    in   1               load base_addr/num_sets; sampled only in IDLE
//   base_addr   in   ADDR_WIDTH      address of the layer's set 0
//   num_sets    in   8               weight sets in the layer; 0 is treated as 1
//   load_start  in   1               fetch request; level-sampled in IDLE only
//   mem_rd_en   out  1               memory read strobe
//   mem_addr    out  ADDR_WIDTH      memory read address
//   mem_rdata   in   WEIGHT_WIDTH    read data, valid RD_LAT cycles after mem_rd_en
//   weight0_out out  9*WEIGHT_WIDTH  kernel 0; tap t at [t*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   weight1_out out  9*WEIGHT_WIDTH  kernel 1; same packing
//   weight2_out out  9*WEIGHT_WIDTH  kernel 2; same packing
//   weight3_out out  9*WEIGHT_WIDTH  kernel 3; same packing
//   load_done   out  1               1-cycle pulse; weight*_out are new in this cycle
//   busy        out  1               high in FETCH, DRAIN and DONE
// BEHAVIOUR
//   Reset (async): state=IDLE; set_idx=0; cfg registers=0; every output=0.
//     Reset mid-fetch abandons the fetch with no load_done.
//     Read data returning after reset is ignored.
//   Memory layout: weight (set s, kernel k, tap t) is at base + s*36 + k*9 + t.
//   States:
//     IDLE : cfg_load=1 -> latch base_addr and num_sets, set_idx<=0, stay in IDLE.
//              cfg_load has priority over load_start in the same cycle.
//            else load_start=1 -> FETCH, rd_cnt<=0.
//     FETCH: mem_rd_en=1; mem_addr = base + set_idx*36 + rd_cnt.
//            rd_cnt 0..35 over 36 consecutive cycles; after rd_cnt=35 -> DRAIN.
//     DRAIN: wait until all 36 returns are captured -> DONE.
//     DONE : load_done=1 for exactly one cycle; advance set_idx; -> IDLE.
//   set_idx advance: set_idx = (set_idx == max(num_sets,1)-1) ? 0 : set_idx+1.
//   Capture path:
//     - A delay line of depth RD_LAT tags each read with its rd_cnt.
//     - Returned data is written to shadow registers, never directly to outputs.
//     - weight*_out load all four shadows at the edge entering DONE.
//     - Outputs hold until the next DONE.
//     - Outputs are therefore stable for at least 37 cycles after any load_start.
//       The downstream controller latches them one cycle after load_start.
//   Latency: with load_start seen in IDLE in cycle T:
//     - reads are issued in cycles T+1..T+36;
//     - load_done is high in cycle T+37+RD_LAT (T+38 when RD_LAT=1).
//   Handshake:
//     - load_start is ignored while busy; requests are neither queued nor counted.
//     - load_start still high in the IDLE cycle after DONE starts the next fetch.
//       This gives back-to-back prefetch.
//   mem_addr: holds its last value when mem_rd_en=0; wraps modulo 2^ADDR_WIDTH.
// TESTING
//   1. Reset; cfg base=0x100, num_sets=2; mem[a]=a[7:0]; pulse load_start at T.
//      -> rd_en high for T+1..T+36 with addr 0x100..0x123.
//      -> load_done only at T+38; weight0_out tap0=0x00 and tap8=0x08; weight3_out tap8=0x23.
//   2. Three 1-cycle fetches with num_sets=2.
//      -> base addresses 0x100, 0x124, then 0x100 (wrap); each load_done is a single cycle.
//   3. Hold load_start high continuously.
//      -> the next fetch issues its first read the cycle after IDLE is re-entered;
//      -> each new set appears only with its own load_done.
//   4. Pulse load_start again during FETCH.
//      -> ignored: exactly one load_done, and set_idx advances by 1.
//   5. Assert rst at read 20.
//      -> all outputs 0 immediately; no load_done; next fetch starts again at set 0.
//   6. RD_LAT=3 and num_sets=0.
//      -> load_done at T+40; set_idx stays 0; weights are correct.

Source files
------------

// File: rtl/weight_fetch.sv
// Fetches one 4-kernel x 9-tap weight set per request, one weight per read.
// It packs the kernels into shadow registers and publishes them with a one-cycle load_done pulse.
module weight_fetch #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int RD_LAT       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_load,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [7:0]                num_sets,
  input  logic                      load_start,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [WEIGHT_WIDTH-1:0]   mem_rdata,
  output logic [9*WEIGHT_WIDTH-1:0] weight0_out,
  output logic [9*WEIGHT_WIDTH-1:0] weight1_out,
  output logic [9*WEIGHT_WIDTH-1:0] weight2_out,
  output logic [9*WEIGHT_WIDTH-1:0] weight3_out,
  output logic                      load_done,
  output logic                      busy
);

  localparam int KW = 9 * WEIGHT_WIDTH;
  localparam int NW = 36;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [7:0]              nsets_reg;
  logic [7:0]              set_idx;
  logic [7:0]              last_set;
  logic [13:0]             set_off;
  logic [5:0]              rd_cnt;
  logic [RD_LAT-1:0]       pv;
  logic [5:0]              pidx [RD_LAT];
  logic [NW*WEIGHT_WIDTH-1:0] shadow;
  logic [NW*WEIGHT_WIDTH-1:0] shadow_nxt;
  logic                    last_ret;

  assign set_off  = 14'(set_idx) * 14'd36;
  assign last_set = (nsets_reg == 8'd0) ? 8'd0 : nsets_reg - 8'd1;
  assign last_ret = pv[RD_LAT-1] && (pidx[RD_LAT-1] == 6'd35);

  // The final return lands on the same edge that enters DONE, so outputs load from the merged view.
  always_comb begin
    shadow_nxt = shadow;
    if (pv[RD_LAT-1]) begin
      for (int i = 0; i < NW; i++) begin
        if (pidx[RD_LAT-1] == 6'(i)) shadow_nxt[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_reg    <= '0;
      nsets_reg   <= '0;
      set_idx     <= '0;
      rd_cnt      <= '0;
      pv          <= '0;
      for (int i = 0; i < RD_LAT; i++) pidx[i] <= '0;
      shadow      <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      weight0_out <= '0;
      weight1_out <= '0;
      weight2_out <= '0;
      weight3_out <= '0;
      load_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shadow    <= shadow_nxt;
      pv[0]     <= mem_rd_en;
      pidx[0]   <= rd_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load) begin
            base_reg  <= base_addr;
            nsets_reg <= num_sets;
            set_idx   <= '0;
          end else if (load_start) begin
            state     <= FETCH;
            rd_cnt    <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_reg + ADDR_WIDTH'(set_off);
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_cnt == 6'd35) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            rd_cnt   <= rd_cnt + 6'd1;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (last_ret) begin
            state       <= DONE;
            load_done   <= 1'b1;
            weight0_out <= shadow_nxt[0*KW +: KW];
            weight1_out <= shadow_nxt[1*KW +: KW];
            weight2_out <= shadow_nxt[2*KW +: KW];
            weight3_out <= shadow_nxt[3*KW +: KW];
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          set_idx <= (set_idx == last_set) ? 8'd0 : set_idx + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench: two DUTs (RD_LAT=1 and RD_LAT=3), each backed by a memory returning mem[a]=a[7:0].
module tb_weight_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        cfg_a, cfg_b, start_a, start_b;
  logic [11:0] base_a, base_b;
  logic [7:0]  nsets_a, nsets_b;
  logic        rd_a, rd_b, done_a, done_b, busy_a, busy_b;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [71:0] w0_a, w1_a, w2_a, w3_a, w0_b, w1_b, w2_b, w3_b;
  logic [7:0]  mb [3];

  weight_fetch #(.WEIGHT_WIDTH(8), .ADDR_WIDTH(12), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_a), .base_addr(base_a), .num_sets(nsets_a),
    .load_start(start_a), .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .weight0_out(w0_a), .weight1_out(w1_a), .weight2_out(w2_a), .weight3_out(w3_a),
    .load_done(done_a), .busy(busy_a));

  weight_fetch #(.WEIGHT_WIDTH(8), .ADDR_WIDTH(12), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_b), .base_addr(base_b), .num_sets(nsets_b),
    .load_start(start_b), .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .weight0_out(w0_b), .weight1_out(w1_b), .weight2_out(w2_b), .weight3_out(w3_b),
    .load_done(done_b), .busy(busy_b));

  always @(posedge clk) begin
    rdata_a <= addr_a[7:0];
    mb[0]   <= addr_b[7:0];
    mb[1]   <= mb[0];
    mb[2]   <= mb[1];
  end
  assign rdata_b = mb[2];

  bit sel = 1'b0;
  wire        o_rd   = sel ? rd_b   : rd_a;
  wire        o_done = sel ? done_b : done_a;
  wire [11:0] o_addr = sel ? addr_b : addr_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic cfg(input bit s, input logic [11:0] b, input logic [7:0] n);
    @(negedge clk);
    if (s) begin cfg_b = 1'b1; base_b = b; nsets_b = n; end
    else   begin cfg_a = 1'b1; base_a = b; nsets_a = n; end
    @(negedge clk);
    cfg_a = 1'b0;
    cfg_b = 1'b0;
  endtask

  // One request pulse at t0; optional second pulse at offset 'mid' while busy.
  task automatic fetch(input int mid, output int t0, output int first_rd, output int last_rd,
                       output int nrd, output int done_c, output int ndone,
                       output logic [11:0] a0, output bit seq_ok);
    logic [11:0] prev;
    prev = '0;
    @(negedge clk);
    set_start(1'b1);
    t0 = cyc; first_rd = -1; last_rd = -1; nrd = 0; done_c = -1; ndone = 0; a0 = '0; seq_ok = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (o_rd) begin
        if (nrd == 0) begin
          first_rd = cyc;
          a0 = o_addr;
        end else if (o_addr != 12'(prev + 12'd1)) seq_ok = 1'b0;
        prev = o_addr;
        last_rd = cyc;
        nrd++;
      end
      if (o_done) begin
        ndone++;
        done_c = cyc;
      end
      if (i == 1 || (mid > 0 && i == mid + 1)) set_start(1'b0);
      else if (mid > 0 && i == mid) set_start(1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, fr, lr, nrd, dc, nd, d1, d2, rs2, bad, cnt;
    logic [11:0] a0;
    bit ok, prev_rd;
    logic [71:0] wprev0, wprev3, w_at_d2;

    rst = 1'b1;
    cfg_a = 0; cfg_b = 0; start_a = 0; start_b = 0;
    base_a = 0; base_b = 0; nsets_a = 0; nsets_b = 0;
    repeat (2) @(negedge clk);
    check("reset_rd_en", rd_a, 0);
    check("reset_addr", addr_a, 0);
    check("reset_done", done_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_w0", w0_a, 0);
    rst = 1'b0;

    // 1: first set, latency and packing
    cfg(0, 12'h100, 8'd2);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t1_first_rd", fr, t0 + 1);
    check("t1_last_rd", lr, t0 + 36);
    check("t1_nrd", nrd, 36);
    check("t1_addr0", a0, 12'h100);
    check("t1_addr_seq", ok, 1);
    check("t1_done_cyc", dc, t0 + 38);
    check("t1_ndone", nd, 1);
    check("t1_w0_tap0", w0_a[7:0], 8'h00);
    check("t1_w0_tap8", w0_a[71:64], 8'h08);
    check("t1_w3_tap8", w3_a[71:64], 8'h23);
    check("t1_busy_after", busy_a, 0);

    // 2: set progression and wrap
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t2_addr0_set1", a0, 12'h124);
    check("t2_ndone_set1", nd, 1);
    check("t2_w0_tap0", w0_a[7:0], 8'h24);
    check("t2_w3_tap8", w3_a[71:64], 8'h47);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t2_addr0_wrap", a0, 12'h100);
    check("t2_ndone_wrap", nd, 1);

    // 4: extra request while busy is dropped
    fetch(10, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t4_addr0", a0, 12'h124);
    check("t4_ndone", nd, 1);
    check("t4_nrd", nrd, 36);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t4_next_addr0", a0, 12'h100);

    // 5: reset at read 20 of set 1
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_read20_addr", addr_a, 12'h138);
    rst = 1'b1;
    #1;
    check("t5_rst_rd_en", rd_a, 0);
    check("t5_rst_addr", addr_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_w0", w0_a, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (25) begin @(negedge clk); if (done_a) cnt++; end
    check("t5_no_done", cnt, 0);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t5_restart_addr0", a0, 12'h000);
    check("t5_restart_ndone", nd, 1);
    check("t5_restart_w0_tap1", w0_a[15:8], 8'h01);

    // 3: load_start held high -> back-to-back fetches
    cfg(0, 12'h100, 8'd2);
    @(negedge clk);
    start_a = 1'b1;
    t0 = cyc; d1 = -1; d2 = -1; rs2 = -1; bad = 0; prev_rd = 1'b0;
    wprev0 = w0_a; wprev3 = w3_a; w_at_d2 = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if ((w0_a != wprev0 || w3_a != wprev3) && !done_a) bad++;
      wprev0 = w0_a; wprev3 = w3_a;
      if (done_a) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) begin d2 = cyc; w_at_d2 = w0_a; end
      end
      if (rd_a && !prev_rd && d1 >= 0 && rs2 < 0) rs2 = cyc;
      prev_rd = rd_a;
    end
    start_a = 1'b0;
    check("t3_done1", d1, t0 + 38);
    check("t3_next_first_rd", rs2, d1 + 2);
    check("t3_done2", d2, d1 + 39);
    check("t3_change_only_on_done", bad, 0);
    check("t3_set1_w0_tap0", w_at_d2[7:0], 8'h24);
    repeat (45) @(negedge clk);

    // 6: RD_LAT=3, num_sets=0
    sel = 1'b1;
    cfg(1, 12'h200, 8'd0);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t6_addr0", a0, 12'h200);
    check("t6_done_cyc", dc, t0 + 40);
    check("t6_ndone", nd, 1);
    check("t6_addr_seq", ok, 1);
    check("t6_w0_tap0", w0_b[7:0], 8'h00);
    check("t6_w1_tap0", w1_b[7:0], 8'h09);
    check("t6_w2_tap4", w2_b[39:32], 8'h16);
    check("t6_w3_tap8", w3_b[71:64], 8'h23);
    fetch(0, t0, fr, lr, nrd, dc, nd, a0, ok);
    check("t6_set_stays0", a0, 12'h200);
    check("t6_done_cyc2", dc, t0 + 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
